// File: rtl/signed_divider_if.sv
// Operand/result bundle for the signed 32/16 divider.
// master drives the request; slave is the divider side.
`timescale 1ns/1ps
interface signed_divider_if;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, overflow, div_by_zero
  );
endinterface

// File: rtl/signed_divider.sv
// Signed 32/16 restoring divider with fixed 18-cycle start-to-done latency,
// saturating quotient on overflow or divide-by-zero.
`timescale 1ns/1ps
module signed_divider (
  input logic             clk,
  input logic             rst,
  signed_divider_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_dividend;
  logic [15:0] r_divisor;
  logic [15:0] r_rem;
  logic [15:0] r_lo;
  logic [16:0] r_dvsr;
  logic [3:0]  r_cnt;
  logic        r_sign;
  logic        r_neg_dvd;
  logic        r_zero;
  logic        r_preovf;
  logic [15:0] r_quotient;
  logic [15:0] r_remainder;
  logic        r_overflow;
  logic        r_div_by_zero;
  logic        w_busy;
  logic        w_done;

  logic [31:0] w_dvd_abs;
  logic [16:0] w_dvs_abs;
  logic [16:0] w_trial;
  logic        w_ge;
  logic [15:0] w_diff;
  logic        w_mag_ovf;
  logic        w_ovf;
  logic [15:0] w_sat;
  logic [15:0] w_fix_q;
  logic [15:0] w_fix_r;

  // Negating -2^31 / -32768 wraps back to the same bit pattern, which is the
  // correct unsigned magnitude at these widths.
  assign w_dvd_abs = r_dividend[31] ? (32'd0 - r_dividend) : r_dividend;
  assign w_dvs_abs = 17'd0 - {r_divisor[15], r_divisor};

  // Remainder stays below the divisor, so a 16-bit difference is exact.
  assign w_trial = {r_rem, r_lo[15]};
  assign w_ge    = (w_trial >= r_dvsr);
  assign w_diff  = w_trial[15:0] - r_dvsr[15:0];

  assign w_mag_ovf = r_sign ? (r_lo > 16'h8000) : (r_lo > 16'h7FFF);
  assign w_ovf     = r_preovf | w_mag_ovf;
  assign w_sat     = r_sign ? 16'h8000 : 16'h7FFF;

  always_comb begin
    w_fix_q = r_sign ? (16'd0 - r_lo) : r_lo;
    w_fix_r = r_neg_dvd ? (16'd0 - r_rem) : r_rem;
    if (r_zero) begin
      w_fix_q = r_neg_dvd ? 16'h8000 : 16'h7FFF;
      w_fix_r = 16'h0000;
    end else if (w_ovf) begin
      w_fix_q = w_sat;
      w_fix_r = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_PREP;
      S_PREP:  w_state_next = S_ITER;
      S_ITER:  if (r_cnt == 4'd15) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_PREP, S_ITER, S_FIX: w_busy = 1'b1;
      S_DONE:                w_done = 1'b1;
      default:               ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend    <= 32'd0;
      r_divisor     <= 16'd0;
      r_rem         <= 16'd0;
      r_lo          <= 16'd0;
      r_dvsr        <= 17'd0;
      r_cnt         <= 4'd0;
      r_sign        <= 1'b0;
      r_neg_dvd     <= 1'b0;
      r_zero        <= 1'b0;
      r_preovf      <= 1'b0;
      r_quotient    <= 16'd0;
      r_remainder   <= 16'd0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
          end
        end
        S_PREP: begin
          r_rem     <= w_dvd_abs[31:16];
          r_lo      <= w_dvd_abs[15:0];
          r_dvsr    <= r_divisor[15] ? w_dvs_abs : {1'b0, r_divisor};
          r_sign    <= r_dividend[31] ^ r_divisor[15];
          r_neg_dvd <= r_dividend[31];
          r_zero    <= (r_divisor == 16'd0);
          r_preovf  <= ({1'b0, w_dvd_abs[31:16]} >=
                        (r_divisor[15] ? w_dvs_abs : {1'b0, r_divisor}));
          r_cnt     <= 4'd0;
        end
        S_ITER: begin
          r_rem <= w_ge ? w_diff : w_trial[15:0];
          r_lo  <= {r_lo[14:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        S_FIX: begin
          r_quotient    <= w_fix_q;
          r_remainder   <= w_fix_r;
          r_overflow    <= ~r_zero & w_ovf;
          r_div_by_zero <= r_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.overflow    = r_overflow;
  assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 Parameters SHALL be none; widths are fixed at 32-bit dividend and 16-bit divisor, quotient and remainder.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  32  two's-complement dividend; captured when start is accepted.
REQ-006 divisor  input  16  two's-complement divisor; captured when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-009 quotient  output  16  two's-complement quotient, truncated toward zero.
REQ-010 remainder  output  16  two's-complement remainder; sign follows the dividend.
REQ-011 overflow  output  1  quotient not representable in 16 bits; registered with the result.
REQ-012 div_by_zero  output  1  divisor was zero; registered with the result.

Function
REQ-013 The FSM SHALL have states IDLE, PREP, ITER, FIX and DONE.
REQ-014 Transitions SHALL be:
- IDLE->PREP when start=1.
- PREP->ITER always.
- ITER->FIX after exactly 16 iterations.
- FIX->DONE always.
- DONE->IDLE always.
REQ-015 Operands SHALL be captured only on the accepting edge; later input changes SHALL have no effect on the current operation.
REQ-016 start SHALL be ignored in PREP, ITER, FIX and DONE; no queuing.
REQ-017 busy SHALL be 1 in PREP/ITER/FIX and 0 in IDLE/DONE.
REQ-018 done SHALL be 1 only in DONE.
REQ-019 Fixed latency: if start is accepted at edge N, done SHALL be high for exactly the cycle between edges N+18 and N+19, including the zero-divisor and overflow cases.
REQ-020 PREP SHALL perform these steps:
- Form 32-bit unsigned |dividend|; -2^31 maps to 0x80000000.
- Form 17-bit |divisor|; -32768 maps to 0x8000.
- Record result sign = dividend[31] XOR divisor[15].
- Set a zero flag if divisor == 0.
- Set a pre-overflow flag if |dividend|[31:16] >= |divisor|.
REQ-021 ITER SHALL perform one radix-2 restoring step per cycle on the magnitudes, 16 steps, producing an unsigned 16-bit quotient magnitude and a 16-bit remainder magnitude.
REQ-022 FIX SHALL apply signs:
- quotient = negated magnitude if the result sign is 1.
- remainder = negated magnitude if dividend was negative.
REQ-023 Overflow SHALL be set when either:
- the pre-overflow flag is set; or
- the magnitude exceeds 0x7FFF for a positive result; or
- the magnitude exceeds 0x8000 for a negative result.
REQ-024 On overflow, outputs SHALL be: quotient = 0x7FFF for a positive result or 0x8000 for a negative result; remainder = 0x0000; overflow = 1.
REQ-025 On a zero divisor, outputs SHALL be:
- div_by_zero = 1 and overflow = 0.
- quotient = 0x7FFF if dividend >= 0, else 0x8000.
- remainder = 0x0000.
REQ-026 A zero divisor SHALL take priority over overflow.
REQ-027 quotient, remainder, overflow and div_by_zero SHALL be written only on the FIX->DONE edge and SHALL hold until the next FIX->DONE edge.
REQ-028 A zero dividend SHALL give quotient 0 and remainder 0 with no flags.

Reset
REQ-029 When rst=1 at a rising edge, the next state SHALL be:
- FSM state IDLE.
- busy = 0, done = 0.
- quotient = 0x0000, remainder = 0x0000.
- overflow = 0, div_by_zero = 0.
REQ-030 rst SHALL take priority over start.
REQ-031 rst asserted mid-operation SHALL abort the operation: no done pulse and no result update.
REQ-032 The first start at least one edge after rst deasserts SHALL be accepted normally.

Verification
REQ-033 Basic division: dividend=100, divisor=7, start at edge N -> quotient=0x000E, remainder=0x0002, flags 0, done only in cycle N+18.
REQ-034 Sign handling:
- -100/7 -> quotient 0xFFF2, remainder 0xFFFE.
- 100/-7 -> quotient 0xFFF2, remainder 0x0002.
- -100/-7 -> quotient 0x000E, remainder 0xFFFE.
REQ-035 Range boundaries:
- 0xFFFF8000/1 -> quotient 0x8000, overflow 0.
- 0x00008000/1 -> quotient 0x7FFF, overflow 1.
- 0x80000000/0xFFFF -> quotient 0x7FFF, overflow 1.
- 0x7FFFFFFF/0x7FFF -> overflow 1.
REQ-036 Zero divisor:
- 1234/0 -> div_by_zero 1, quotient 0x7FFF, remainder 0, done at N+18.
- -5/0 -> quotient 0x8000.
REQ-037 Handshake: start held high throughout an operation with changing operands -> the first operands' result is returned; the next operation is accepted only from IDLE at edge N+19 or later.
REQ-038 Reset mid-operation: rst=1 at edge N+8 -> busy=0 after that edge; no done pulse; outputs 0; the following 100/7 run completes correctly.
